// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, a write-loadable instruction memory and a
// 2-entry {pc, instr} buffer feeding decode. Optional IFETCH_PERF_EN adds stall_cnt.
module ifetch_stage #(
   parameter int                 ADDR_W  = 4,
   parameter int                 INSTR_W = 8,
   parameter logic [INSTR_W-1:0] HALT_OP = 8'hFF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   input  logic               imem_we,
   input  logic [ADDR_W-1:0]  imem_waddr,
   input  logic [INSTR_W-1:0] imem_wdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted
`ifdef IFETCH_PERF_EN
   ,
   output logic [15:0]        stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

   state_t             state;
   logic [INSTR_W-1:0] mem [2**ADDR_W];
   logic [ADDR_W-1:0]  buf_pc [2];
   logic [INSTR_W-1:0] buf_instr [2];
   logic [1:0]         count;
   logic [INSTR_W-1:0] fetch_instr;
   logic               pop;
   logic               push;

   assign fetch_instr = mem[pc];
   assign out_valid   = (count != 2'd0) && !redirect_valid;
   assign pop         = out_valid && out_ready;
   assign push        = (state == FETCH) && !redirect_valid && ((count < 2'd2) || pop);
   assign out_pc      = buf_pc[0];
   assign out_instr   = buf_instr[0];

   // Memory is deliberately not reset; the read is combinational so a write lands after the edge.
   always_ff @(posedge clk) begin
      if (imem_we) begin
         mem[imem_waddr] <= imem_wdata;
      end
   end

   // Slot 0 is always the head; a redirect discards everything buffered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count        <= 2'd0;
         buf_pc[0]    <= '0;
         buf_pc[1]    <= '0;
         buf_instr[0] <= '0;
         buf_instr[1] <= '0;
      end else if (redirect_valid) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  buf_pc[0]    <= pc;
                  buf_instr[0] <= fetch_instr;
               end else begin
                  buf_pc[1]    <= pc;
                  buf_instr[1] <= fetch_instr;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               buf_pc[0]    <= buf_pc[1];
               buf_instr[0] <= buf_instr[1];
               count        <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  buf_pc[0]    <= pc;
                  buf_instr[0] <= fetch_instr;
               end else begin
                  buf_pc[0]    <= buf_pc[1];
                  buf_instr[0] <= buf_instr[1];
                  buf_pc[1]    <= pc;
                  buf_instr[1] <= fetch_instr;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc     <= '0;
         halted <= 1'b0;
      end else if (redirect_valid) begin
         pc     <= redirect_addr;
         halted <= 1'b0;
         if ((state == IDLE) && !start) begin
            state <= IDLE;
         end else begin
            state <= FETCH;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (push) begin
                  pc <= pc + 1'b1;
                  if (fetch_instr == HALT_OP) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end
               end
            end
            HALT: ;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IFETCH_PERF_EN
   // Counts cycles the decoder refuses a valid head; saturates rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 16'd0;
      end else if (redirect_valid) begin
         stall_cnt <= 16'd0;
      end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: a per-cycle vector table for fetch, halt and
// backpressure, then hand sequences for wrap, flush, reset and the perf counter.
module tb_ifetch_stage;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       redirect_valid;
   logic [3:0] redirect_addr;
   logic       imem_we;
   logic [3:0] imem_waddr;
   logic [7:0] imem_wdata;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_instr;
   logic [3:0] out_pc;
   logic [3:0] pc;
   logic       halted;
`ifdef IFETCH_PERF_EN
   logic [15:0] stall_cnt;
`endif

   int compared = 0;
   int mismatched = 0;

   ifetch_stage dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .redirect_valid(redirect_valid),
      .redirect_addr(redirect_addr),
      .imem_we(imem_we),
      .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc),
      .pc(pc),
      .halted(halted)
`ifdef IFETCH_PERF_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic       redir;
      logic [3:0] raddr;
      logic       ready;
      logic       valid;
      logic [3:0] opc;
      logic [7:0] oinstr;
      logic [3:0] pc;
      logic       halted;
   } vec_t;

   vec_t vecs[18];

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic apply_stimulus(input logic s, input logic rv, input logic [3:0] ra, input logic rdy);
      @(negedge clk);
      imem_we        = 1'b0;
      start          = s;
      redirect_valid = rv;
      redirect_addr  = ra;
      out_ready      = rdy;
      #1;
   endtask

   task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      start          = 1'b0;
      redirect_valid = 1'b0;
      imem_we        = 1'b1;
      imem_waddr     = a;
      imem_wdata     = d;
   endtask

   task automatic check_head(input string tag, input logic v, input logic [3:0] opc,
                             input logic [7:0] oi, input logic [3:0] p, input logic h);
      check_output({tag, " out_valid"}, {15'd0, out_valid}, {15'd0, v});
      if (v) begin
         check_output({tag, " out_pc"}, {12'd0, out_pc}, {12'd0, opc});
         check_output({tag, " out_instr"}, {8'd0, out_instr}, {8'd0, oi});
      end
      check_output({tag, " pc"}, {12'd0, pc}, {12'd0, p});
      check_output({tag, " halted"}, {15'd0, halted}, {15'd0, h});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_n          = 1'b0;
      start          = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = 4'h0;
      imem_we        = 1'b0;
      imem_waddr     = 4'h0;
      imem_wdata     = 8'h00;
      out_ready      = 1'b0;

      // start, redir, raddr, ready | valid, out_pc, out_instr, pc, halted (pre-edge)
      vecs[0]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 8'h11, 4'h1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 8'h22, 4'h2, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 8'h33, 4'h3, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 8'hFF, 4'h4, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h4, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h4, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 8'h11, 4'h1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 8'h11, 4'h2, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 8'h11, 4'h2, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 8'h11, 4'h2, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 8'h22, 4'h3, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 8'h33, 4'h4, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 8'hFF, 4'h4, 1'b1};
      vecs[16] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h4, 1'b1};
      vecs[17] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h4, 1'b1};

      #12;
      check_output("reset out_valid", {15'd0, out_valid}, 16'd0);
      check_output("reset pc", {12'd0, pc}, 16'd0);
      check_output("reset halted", {15'd0, halted}, 16'd0);
      check_output("reset out_pc", {12'd0, out_pc}, 16'd0);
      check_output("reset out_instr", {8'd0, out_instr}, 16'd0);
`ifdef IFETCH_PERF_EN
      check_output("reset stall_cnt", stall_cnt, 16'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      write_mem(4'h0, 8'h11);
      write_mem(4'h1, 8'h22);
      write_mem(4'h2, 8'h33);
      write_mem(4'h3, 8'hFF);
      for (int a = 4; a < 16; a++) write_mem(a[3:0], 8'h01);

      for (int i = 0; i < 18; i++) begin
         apply_stimulus(vecs[i].start, vecs[i].redir, vecs[i].raddr, vecs[i].ready);
         check_head($sformatf("v%0d", i), vecs[i].valid, vecs[i].opc, vecs[i].oinstr,
                    vecs[i].pc, vecs[i].halted);
      end

      // Wrap from E through F to 0 with memory all 8'h01, then flush a full buffer.
      for (int a = 0; a < 16; a++) write_mem(a[3:0], 8'h01);
      apply_stimulus(1'b0, 1'b1, 4'hE, 1'b1);
      check_output("halt redir out_valid", {15'd0, out_valid}, 16'd0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1);
      check_head("wrap0", 1'b0, 4'h0, 8'h00, 4'hE, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1);
      check_head("wrapE", 1'b1, 4'hE, 8'h01, 4'hF, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1);
      check_head("wrapF", 1'b1, 4'hF, 8'h01, 4'h0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1);
      check_head("wrap0b", 1'b1, 4'h0, 8'h01, 4'h1, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1);
      check_head("wrap1", 1'b1, 4'h1, 8'h01, 4'h2, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
      check_head("fill1", 1'b1, 4'h2, 8'h01, 4'h3, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
      check_head("fill2", 1'b1, 4'h2, 8'h01, 4'h4, 1'b0);
      apply_stimulus(1'b0, 1'b1, 4'h8, 1'b1);
      check_output("flush out_valid", {15'd0, out_valid}, 16'd0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1);
      check_head("postflush", 1'b0, 4'h0, 8'h00, 4'h8, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1);
      check_head("redir8", 1'b1, 4'h8, 8'h01, 4'h9, 1'b0);

      // Asynchronous reset with a full buffer, then nothing until start.
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
      check_head("prerst1", 1'b1, 4'h9, 8'h01, 4'hA, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
      check_head("prerst2", 1'b1, 4'h9, 8'h01, 4'hB, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_head("inrst", 1'b0, 4'h0, 8'h00, 4'h0, 1'b0);
      check_output("inrst out_pc", {12'd0, out_pc}, 16'd0);
`ifdef IFETCH_PERF_EN
      check_output("inrst stall_cnt", stall_cnt, 16'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1);
      check_head("idle1", 1'b0, 4'h0, 8'h00, 4'h0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1);
      check_head("idle2", 1'b0, 4'h0, 8'h00, 4'h0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
      check_head("restart", 1'b0, 4'h0, 8'h00, 4'h0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
      check_head("restart1", 1'b0, 4'h0, 8'h00, 4'h0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
      check_head("restart2", 1'b1, 4'h0, 8'h01, 4'h1, 1'b0);
`ifdef IFETCH_PERF_EN
      check_output("stall0", stall_cnt, 16'd0);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
      check_output("stall1", stall_cnt, 16'd1);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
      check_output("stall2", stall_cnt, 16'd2);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1);
      check_output("stall3", stall_cnt, 16'd3);
      apply_stimulus(1'b0, 1'b1, 4'h0, 1'b1);
      check_output("stall held", stall_cnt, 16'd3);
      apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1);
      check_output("stall cleared", stall_cnt, 16'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction fetch stage that owns the CPU program counter.
- Holds a small write-loadable instruction memory.
- Streams {pc, instruction} pairs through a 2-entry buffer to the decoder using a valid/ready handshake.
- Supports start, halt-on-opcode, and branch redirect with buffer flush. Sits directly downstream of the free-running 4-bit count logic and replaces it as the PC source for decode.

Parameters:
ADDR_W, 4, PC / memory address width; memory depth 2^ADDR_W
INSTR_W, 8, instruction width
HALT_OP, 8'hFF, instruction value that stops fetching (full-word compare, INSTR_W bits)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; IDLE -> FETCH
redirect_valid  in  1  branch redirect request
redirect_addr  in  ADDR_W  redirect target PC
imem_we  in  1  instruction memory write enable
imem_waddr  in  ADDR_W  write address
imem_wdata  in  INSTR_W  write data
out_valid  out  1  buffer head valid to decoder
out_ready  in  1  decoder accepts head
out_instr  out  INSTR_W  head instruction
out_pc  out  ADDR_W  PC of head instruction
pc  out  ADDR_W  next fetch address
halted  out  1  high while in HALT

Behaviour:
- Reset (async, rst_n low): state=IDLE, pc=0, buffer count=0, out_valid=0, out_instr=0, out_pc=0, halted=0. Memory contents are not reset.
- Memory: synchronous write on imem_we. Combinational read at pc. A same-cycle write to the address being read returns the old data.
- Buffer: 2-entry FIFO of {pc, instr}.
  - out_valid = (count!=0) && !redirect_valid.
  - Pop when out_valid && out_ready.
  - Push is allowed when count<2, or when count==2 and a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged; order is preserved.
- States:
  - IDLE: no fetch. start -> FETCH. redirect_valid in IDLE loads pc=redirect_addr and stays in IDLE.
  - FETCH: each cycle a push is allowed, push {pc, imem[pc]} and set pc <= pc+1, wrapping modulo 2^ADDR_W (4'hF -> 0). If the pushed instr == HALT_OP -> HALT. The HALT_OP word itself is delivered to the decoder. If a push is not allowed (buffer full), pc holds (stall).
  - HALT: no fetch; halted=1. The buffer continues draining. redirect_valid -> FETCH. start is ignored.
- Redirect (FETCH or HALT): at that edge the buffer is flushed (count=0), pc <= redirect_addr, state -> FETCH. Redirect has priority over push and pop in the same cycle; no handshake completes on a redirect cycle.
- start and redirect in the same IDLE cycle: pc <= redirect_addr and state -> FETCH.
- Latency: start sampled at edge N -> first push at edge N+1 -> out_valid high after edge N+1, with out_pc equal to the pc at start time. Sustained throughput is 1 instruction/cycle while out_ready=1.
- Reset mid-operation: all state returns to reset values immediately; any in-flight buffer entries are lost.

Optional Feature:
IFETCH_PERF_EN
- Defined: adds output port stall_cnt[15:0], reset to 0.
  - Increments on every cycle with out_valid && !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared on redirect.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Load imem[0..3]={8'h11,8'h22,8'h33,8'hFF}, out_ready=1, pulse start -> out_pc/out_instr 0/11, 1/22, 2/33, 3/FF on consecutive cycles; halted=1; pc=4; out_valid then low.
- Same program, out_ready=0 for 5 cycles after start -> count reaches 2 holding 0/11 and 1/22; pc=2 held. Release ready -> sequence continues 0/11, 1/22, 2/33 with no loss or duplicate.
- Fill imem with 8'h01, pc=4'hE, out_ready=1 -> out_pc sequence E, F, 0, 1 (wrap).
- Mid-stream redirect_valid=1, redirect_addr=4'h8 with 2 entries buffered -> out_valid low that cycle. Next accepted out_pc=8; flushed entries are never delivered.
- While halted, redirect_addr=4'h0 -> halted deasserts next cycle; fetch restarts with out_pc=0.
- rst_n pulsed low mid-FETCH with a full buffer -> out_valid=0, pc=0, state IDLE at once. No fetch until start. With IFETCH_PERF_EN defined: 3 backpressure cycles give stall_cnt=3.
